// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared sideband types, header layout and parity helpers (SB_DEC_PARITY_CHK_EN enables parity checks)
package sb_pkg;

`ifdef SB_DEC_PARITY_CHK_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      RESET      = 3'd0,
      SBINIT     = 3'd1,
      MBINIT     = 3'd2,
      MBTRAIN    = 3'd3,
      LINKINIT   = 3'd4,
      ACTIVE     = 3'd5,
      PHYRETRAIN = 3'd6,
      TRAINERROR = 3'd7
   } e_states;

   typedef enum logic [3:0] {
      PARAM      = 4'd0,
      CAL        = 4'd1,
      REPAIRCLK  = 4'd2,
      REPAIRVAL  = 4'd3,
      REVERSALMB = 4'd4,
      REPAIRMB   = 4'd5
   } e_sub_states_MBINIT;

   typedef enum logic [3:0] {
      VALREF           = 4'd0,
      DATAVREF         = 4'd1,
      SPEEDIDLE        = 4'd2,
      TXSELFCAL        = 4'd3,
      RXCLKCAL         = 4'd4,
      VALTRAINCENTER   = 4'd5,
      VALTRAINVREF     = 4'd6,
      DATATRAINCENTER1 = 4'd7,
      DATATRAINVREF    = 4'd8,
      RXDESKEW         = 4'd9,
      DATATRAINCENTER2 = 4'd10,
      LINKSPEED        = 4'd11,
      REPAIR           = 4'd12
   } e_sub_states_MBTRAIN;

   typedef enum logic {
      S_IDLE,
      S_WAIT_DATA
   } e_dec_fsm;

   localparam logic [4:0] OP_MSG_NODATA = 5'b10010;
   localparam logic [4:0] OP_MSG_DATA   = 5'b11011;

   localparam int OPC_LSB     = 0;
   localparam int OPC_MSB     = 4;
   localparam int MSGCODE_LSB = 14;
   localparam int SRCID_LSB   = 27;
   localparam int MSGSUB_LSB  = 32;
   localparam int DSTID_LSB   = 56;
   localparam int DP_BIT      = 62;
   localparam int CP_BIT      = 63;

   function automatic logic f_cp(input logic [61:0] hdr);
      return ^hdr;
   endfunction

   function automatic logic f_dp(input logic [63:0] payload);
      return ^payload;
   endfunction

endpackage

// File: rtl/sb_hdr_parser.sv
// rtl/sb_hdr_parser.sv - combinational header field extraction and CP compare
module sb_hdr_parser
   import sb_pkg::*;
(
   input  logic [63:0] hdr,
   output logic [2:0]  state,
   output logic [3:0]  sub_state,
   output logic [3:0]  msg_no,
   output logic        dp,
   output logic        cp_ok,
   output logic        is_nodata,
   output logic        is_data
);

   logic [4:0] opcode;

   assign opcode    = hdr[OPC_MSB:OPC_LSB];
   // msgcode is {0, state, sub_state}; msgsubcode is {0, msg_no}
   assign state     = hdr[MSGCODE_LSB+4 +: 3];
   assign sub_state = hdr[MSGCODE_LSB +: 4];
   assign msg_no    = hdr[MSGSUB_LSB +: 4];
   assign dp        = hdr[DP_BIT];
   assign cp_ok     = (f_cp(hdr[61:0]) == hdr[CP_BIT]);
   assign is_nodata = (opcode == OP_MSG_NODATA);
   assign is_data   = (opcode == OP_MSG_DATA);

endmodule

// File: rtl/sb_data_decoder.sv
// rtl/sb_data_decoder.sv - sideband receive decoder: header/payload pairing, parity and timeout (SB_DEC_PARITY_CHK_EN)
module sb_data_decoder
   import sb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pckt_valid,
   input  logic [63:0] i_pckt,
   output logic        o_msg_valid,
   output logic        o_data_valid,
   output logic [2:0]  o_state,
   output logic [3:0]  o_sub_state,
   output logic [3:0]  o_msg_no,
   output logic [15:0] o_data_bus,
   output logic        o_busy,
   output logic        o_parity_err,
   output logic        o_opcode_err,
   output logic        o_timeout_err
);

   logic [2:0] p_state;
   logic [3:0] p_sub_state;
   logic [3:0] p_msg_no;
   logic       p_dp;
   logic       p_cp_ok;
   logic       p_is_nodata;
   logic       p_is_data;

   sb_hdr_parser u_parser (
      .hdr       (i_pckt),
      .state     (p_state),
      .sub_state (p_sub_state),
      .msg_no    (p_msg_no),
      .dp        (p_dp),
      .cp_ok     (p_cp_ok),
      .is_nodata (p_is_nodata),
      .is_data   (p_is_data)
   );

   e_dec_fsm   fsm;
   logic [7:0] idle_cnt;
   logic [2:0] lat_state;
   logic [3:0] lat_sub_state;
   logic [3:0] lat_msg_no;
   logic       lat_dp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fsm           <= S_IDLE;
         idle_cnt      <= '0;
         lat_state     <= '0;
         lat_sub_state <= '0;
         lat_msg_no    <= '0;
         lat_dp        <= 1'b0;
         o_msg_valid   <= 1'b0;
         o_data_valid  <= 1'b0;
         o_state       <= '0;
         o_sub_state   <= '0;
         o_msg_no      <= '0;
         o_data_bus    <= '0;
         o_busy        <= 1'b0;
         o_parity_err  <= 1'b0;
         o_opcode_err  <= 1'b0;
         o_timeout_err <= 1'b0;
      end else begin
         o_msg_valid   <= 1'b0;
         o_data_valid  <= 1'b0;
         o_parity_err  <= 1'b0;
         o_opcode_err  <= 1'b0;
         o_timeout_err <= 1'b0;
         case (fsm)
            S_IDLE: begin
               if (i_pckt_valid) begin
                  // opcode is judged before CP so an unknown beat never reports parity
                  if (!p_is_nodata && !p_is_data) begin
                     o_opcode_err <= 1'b1;
                  end else if (PARITY_EN && !p_cp_ok) begin
                     o_parity_err <= 1'b1;
                  end else if (p_is_nodata) begin
                     o_msg_valid <= 1'b1;
                     o_state     <= p_state;
                     o_sub_state <= p_sub_state;
                     o_msg_no    <= p_msg_no;
                  end else begin
                     lat_state     <= p_state;
                     lat_sub_state <= p_sub_state;
                     lat_msg_no    <= p_msg_no;
                     lat_dp        <= p_dp;
                     idle_cnt      <= '0;
                     fsm           <= S_WAIT_DATA;
                     o_busy        <= 1'b1;
                  end
               end
            end
            S_WAIT_DATA: begin
               // a beat on the threshold cycle still counts as the payload
               if (i_pckt_valid) begin
                  fsm    <= S_IDLE;
                  o_busy <= 1'b0;
                  if (PARITY_EN && (f_dp(i_pckt) != lat_dp)) begin
                     o_parity_err <= 1'b1;
                  end else begin
                     o_msg_valid  <= 1'b1;
                     o_data_valid <= 1'b1;
                     o_state      <= lat_state;
                     o_sub_state  <= lat_sub_state;
                     o_msg_no     <= lat_msg_no;
                     o_data_bus   <= i_pckt[15:0];
                  end
               end else if (idle_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  fsm           <= S_IDLE;
                  o_busy        <= 1'b0;
                  o_timeout_err <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end
            default: begin
               fsm    <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sb_data_decoder.sv
// tb/tb_sb_data_decoder.sv - randomized bench for sb_data_decoder against a behavioural model
module tb_sb_data_decoder;
   import sb_pkg::*;

   localparam int TO = 8;
`ifdef SB_DEC_PARITY_CHK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_pckt_valid;
   logic [63:0] i_pckt;
   logic        o_msg_valid, o_data_valid, o_busy;
   logic        o_parity_err, o_opcode_err, o_timeout_err;
   logic [2:0]  o_state;
   logic [3:0]  o_sub_state, o_msg_no;
   logic [15:0] o_data_bus;

   always #5 i_clk = ~i_clk;

   sb_data_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_pckt_valid  (i_pckt_valid),
      .i_pckt        (i_pckt),
      .o_msg_valid   (o_msg_valid),
      .o_data_valid  (o_data_valid),
      .o_state       (o_state),
      .o_sub_state   (o_sub_state),
      .o_msg_no      (o_msg_no),
      .o_data_bus    (o_data_bus),
      .o_busy        (o_busy),
      .o_parity_err  (o_parity_err),
      .o_opcode_err  (o_opcode_err),
      .o_timeout_err (o_timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // expected outputs and the model's notion of a pending with-data message
   logic        e_msg_valid, e_data_valid, e_busy, e_perr, e_operr, e_toerr;
   logic [2:0]  e_state;
   logic [3:0]  e_sub, e_msg;
   logic [15:0] e_data;
   bit          m_wait;
   int          m_gap;
   int          m_st, m_sub, m_msg, m_dp;

   function automatic int odd(input logic [63:0] v, input int nbits);
      int c = 0;
      for (int b = 0; b < nbits; b++) c += int'(v[b]);
      return c % 2;
   endfunction

   task automatic model_step(input logic rst, input logic v, input logic [63:0] p);
      int op, st, sub, msg;
      e_msg_valid = 0; e_data_valid = 0; e_perr = 0; e_operr = 0; e_toerr = 0;
      if (rst) begin
         m_wait = 0; m_gap = 0;
         e_state = 0; e_sub = 0; e_msg = 0; e_data = 0;
      end else if (m_wait) begin
         if (v) begin
            m_wait = 0;
            if (PAR && odd(p, 64) != m_dp) e_perr = 1;
            else begin
               e_msg_valid = 1; e_data_valid = 1;
               e_state = 3'(m_st); e_sub = 4'(m_sub); e_msg = 4'(m_msg);
               e_data = 16'(p % 65536);
            end
         end else begin
            m_gap++;
            if (m_gap == TO) begin e_toerr = 1; m_wait = 0; end
         end
      end else if (v) begin
         op  = int'(p % 32);
         st  = int'((p >> 18) % 8);
         sub = int'((p >> 14) % 16);
         msg = int'((p >> 32) % 16);
         if (op != 5'b10010 && op != 5'b11011) e_operr = 1;
         else if (PAR && odd(p, 62) != int'(p[63])) e_perr = 1;
         else if (op == 5'b10010) begin
            e_msg_valid = 1;
            e_state = 3'(st); e_sub = 4'(sub); e_msg = 4'(msg);
         end else begin
            m_wait = 1; m_gap = 0;
            m_st = st; m_sub = sub; m_msg = msg; m_dp = int'(p[62]);
         end
      end
      e_busy = m_wait;
   endtask

   task automatic cyc(input logic rst, input logic v, input logic [63:0] p);
      i_rst = rst; i_pckt_valid = v; i_pckt = p;
      @(posedge i_clk);
      model_step(rst, v, p);
      #1;
      check("msg_valid", o_msg_valid, e_msg_valid);
      check("data_valid", o_data_valid, e_data_valid);
      check("busy", o_busy, e_busy);
      check("parity_err", o_parity_err, e_perr);
      check("opcode_err", o_opcode_err, e_operr);
      check("timeout_err", o_timeout_err, e_toerr);
      check("state", o_state, e_state);
      check("sub_state", o_sub_state, e_sub);
      check("msg_no", o_msg_no, e_msg);
      check("data_bus", o_data_bus, e_data);
   endtask

   function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [2:0] st,
                                          input logic [3:0] sub, input logic [3:0] msg,
                                          input logic [63:0] pl, input bit bad_cp, input bit bad_dp);
      logic [63:0] h;
      h = {$urandom, $urandom};
      h[4:0]   = op;
      h[21:14] = {1'b0, st, sub};
      h[39:32] = {4'h0, msg};
      h[62]    = (^pl) ^ bad_dp;
      h[63]    = (^h[61:0]) ^ bad_cp;
      return h;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [63:0] h, pl;
      int n, cnt_v, cnt_e;
      bit seen;
      i_rst = 1; i_pckt_valid = 0; i_pckt = '0;
      m_wait = 0; m_gap = 0;

      for (int i = 0; i < 3; i++) cyc(1, 1, mk_hdr(OP_MSG_DATA, 3'd2, 4'd1, 4'd1, 64'h0, 0, 0));
      check("rst_busy", o_busy, 0);

      h = mk_hdr(OP_MSG_NODATA, 3'd2, 4'd2, 4'd5, 64'h0, 0, 0);
      cyc(0, 1, h);
      check("nd_valid", o_msg_valid, 1);
      check("nd_state", o_state, 2);
      check("nd_sub", o_sub_state, 2);
      check("nd_msg", o_msg_no, 5);
      check("nd_dvalid", o_data_valid, 0);
      cyc(0, 0, '0);

      pl = 64'h0000_0000_0000_A5C3;
      cyc(0, 1, mk_hdr(OP_MSG_DATA, 3'd2, 4'd0, 4'd3, pl, 0, 0));
      cyc(0, 0, '0);
      check("wd_busy_gap", o_busy, 1);
      cyc(0, 0, '0);
      cyc(0, 1, pl);
      check("wd_dvalid", o_data_valid, 1);
      check("wd_data", o_data_bus, 16'hA5C3);
      check("wd_msg", o_msg_no, 3);

      cyc(0, 1, mk_hdr(OP_MSG_NODATA, 3'd3, 4'd4, 4'd9, 64'h0, 1, 0));
      check("cp_flip_perr", o_parity_err, PAR);
      check("cp_flip_valid", o_msg_valid, !PAR);
      pl = rnd64();
      cyc(0, 1, mk_hdr(OP_MSG_DATA, 3'd5, 4'd1, 4'd7, pl, 0, 1));
      cyc(0, 1, pl);
      check("dp_flip_perr", o_parity_err, PAR);
      check("dp_flip_valid", o_msg_valid, !PAR);

      cyc(0, 1, mk_hdr(OP_MSG_DATA, 3'd1, 4'd1, 4'd1, 64'h0, 0, 0));
      cyc(0, 0, '0);
      cyc(1, 0, '0);
      check("rst_wait_busy", o_busy, 0);
      check("rst_wait_pulse", o_msg_valid | o_timeout_err, 0);
      cyc(0, 0, '0);

      cyc(0, 1, mk_hdr(OP_MSG_DATA, 3'd4, 4'd2, 4'd2, 64'h0, 0, 0));
      n = 0; seen = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         cyc(0, 0, '0);
         if (o_timeout_err) begin seen = 1; n = i; end
      end
      check("to_latency", n, TO);
      check("to_busy", o_busy, 0);

      pl = 64'h1234_5678_9ABC_BEEF;
      cyc(0, 1, mk_hdr(OP_MSG_DATA, 3'd4, 4'd3, 4'd6, pl, 0, 0));
      for (int i = 1; i < TO; i++) cyc(0, 0, '0);
      cyc(0, 1, pl);
      check("thr_valid", o_msg_valid, 1);
      check("thr_data", o_data_bus, 16'hBEEF);
      check("thr_to", o_timeout_err, 0);

      h = rnd64(); h[4:0] = 5'b00001;
      cyc(0, 1, h);
      check("badop_err", o_opcode_err, 1);
      cnt_v = 0; cnt_e = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(0, 1, mk_hdr(OP_MSG_NODATA, 3'($urandom), 4'($urandom), 4'($urandom), 64'h0, 0, 0));
         cnt_v += int'(o_msg_valid);
         cnt_e += int'(o_opcode_err | o_parity_err);
      end
      check("b2b_count", cnt_v, 100);
      check("b2b_errs", cnt_e, 0);

      pl = rnd64();
      for (int i = 0; i < 400; i++) begin
         int r, k;
         r = $urandom_range(0, 99);
         k = $urandom_range(0, 9);
         if (r < 3) cyc(1, 0, '0);
         else if (r < 40) cyc(0, 0, '0);
         else if (m_wait) cyc(0, 1, (k == 0) ? rnd64() : pl);
         else if (k < 4) cyc(0, 1, mk_hdr(OP_MSG_NODATA, 3'($urandom), 4'($urandom), 4'($urandom), 64'h0, k == 0, 0));
         else if (k < 8) begin
            pl = rnd64();
            cyc(0, 1, mk_hdr(OP_MSG_DATA, 3'($urandom), 4'($urandom), 4'($urandom), pl, k == 4, k == 5));
         end else cyc(0, 1, rnd64());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
